spi_req_arbiter: RTL and testbench
==================================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter ADDR_RXDR, default 3'd0, SPI master receive-data register address.
REQ-002 Parameter ADDR_TXDR, default 3'd1, SPI master transmit-data register address.
REQ-003 Parameter ADDR_STATUS, default 3'd2, SPI master status register address.
REQ-004 Parameter RRDY_BIT, default 3, status bit index for "receive byte ready".
REQ-005 Parameter TIMEOUT, default 16'd4095, maximum status polls per transaction.
REQ-006 Ports (name direction width meaning), clock and reset first:
- I_CLK in 1 sole clock, all logic on rising edge
- I_RESETN in 1 reset, asynchronous, active-low
- req_valid in 2 per-requester transaction request
- req_data0, req_data1 in 8 each, byte to send for requester 0/1
- req_ready out 2 one-cycle accept strobe per requester
- rsp_valid out 2 one-cycle response strobe per requester
- rsp_data out 8 received byte, valid with rsp_valid
- rsp_err out 1 timeout flag, valid with rsp_valid
- busy out 1 high while a transaction is in flight
- spi_tx_en out 1 SPI master register write strobe
- spi_waddr out 3 SPI master write address
- spi_wdata out 8 SPI master write data
- spi_rx_en out 1 SPI master register read strobe
- spi_raddr out 3 SPI master read address
- spi_rdata in 8 SPI master read data, valid one cycle after spi_rx_en

Function
REQ-007 States: IDLE, WR_TX, POLL_REQ, POLL_CHK, RD_REQ, RD_CAP, RESP.
REQ-008 IDLE: if any req_valid bit set, grant one requester, pulse its req_ready bit, latch its data, go WR_TX next cycle.
REQ-009 Arbitration round-robin: last_grant register; when both request, grant the one not last granted; after reset last_grant=1 so requester 0 wins first tie.
REQ-010 WR_TX: spi_tx_en=1, spi_waddr=ADDR_TXDR, spi_wdata=latched byte for exactly one cycle; go POLL_REQ.
REQ-011 POLL_REQ: spi_rx_en=1, spi_raddr=ADDR_STATUS one cycle, increment poll counter; go POLL_CHK.
REQ-012 POLL_CHK: spi_rdata[RRDY_BIT]=1 -> RD_REQ; else poll counter == TIMEOUT -> RESP with error; else -> POLL_REQ.
REQ-013 RD_REQ: spi_rx_en=1, spi_raddr=ADDR_RXDR one cycle; RD_CAP: capture spi_rdata into rsp_data; go RESP.
REQ-014 RESP: pulse granted rsp_valid bit one cycle with rsp_data and rsp_err; return IDLE; no new grant in the same cycle.
REQ-015 On timeout rsp_data=8'h00, rsp_err=1; on success rsp_err=0.
REQ-016 Poll counter 16-bit, cleared on grant, saturates (never wraps); TIMEOUT=0 means a single poll before error.
REQ-017 spi_tx_en and spi_rx_en never both high; each high at most one cycle per state visit.
REQ-018 busy=1 in every state except IDLE.
REQ-019 Minimum transaction latency grant-to-rsp_valid: 6 cycles (RRDY set on first poll).
REQ-020 req_valid changes while busy are ignored; a request held through RESP is granted on the following IDLE cycle.
REQ-021 req_valid deasserted before grant: no transaction, no rsp.

Reset
REQ-022 I_RESETN low asynchronously forces IDLE; all outputs 0 (spi_waddr, spi_raddr, spi_wdata, rsp_data = 0), poll counter 0, last_grant=1.
REQ-023 Reset mid-transaction abandons it with no rsp_valid; SPI strobes drop in the same cycle reset asserts.

Structure
REQ-024 Shared package holds state encoding and default register-address/status-bit constants.
REQ-025 One sub-module natural: spi_rr_arb2 (2-way round-robin grant with last_grant state).

Verification
REQ-026 Single req0 0xA5, status RRDY on first poll, RXDR 0x3C -> req_ready[0] then TX write 0xA5 at addr 1, rsp_valid[0] with 0x3C, err 0, 6 cycles after grant.
REQ-027 req0 and req1 both held from reset -> grants alternate 0,1,0,1; each rsp_valid bit matches its grant.
REQ-028 Status RRDY never set, TIMEOUT=3 -> 4 status reads, rsp_valid with rsp_err=1, rsp_data 0x00.
REQ-029 RRDY set on third poll -> exactly 3 status reads, 1 RXDR read, err 0.
REQ-030 I_RESETN low during POLL_CHK -> immediate IDLE, all outputs 0, no rsp_valid; next request served normally with requester 0 preferred.
REQ-031 Assertion across all tests: spi_tx_en & spi_rx_en never 1; at most one req_ready/rsp_valid bit high per cycle.

Source files
------------

// File: rtl/spi_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_req_arbiter_pkg
// Brief   : State encoding and default SPI register map for spi_req_arbiter.
// Revision: 1.0
// ============================================================================
package spi_req_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_TX    = 3'd1,
    ST_POLL_REQ = 3'd2,
    ST_POLL_CHK = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_RD_CAP   = 3'd5,
    ST_RESP     = 3'd6
  } state_t;

  localparam logic [2:0]  C_ADDR_RXDR   = 3'd0;
  localparam logic [2:0]  C_ADDR_TXDR   = 3'd1;
  localparam logic [2:0]  C_ADDR_STATUS = 3'd2;
  localparam int          C_RRDY_BIT    = 3;
  localparam logic [15:0] C_TIMEOUT     = 16'd4095;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_req_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : spi_rr_arb2
// Brief   : Two-way round-robin grant; a tie goes to the requester not last served.
// Revision: 1.0
// ============================================================================
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic r_last_grant;

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (en) begin
      case (req)
        2'b01: begin grant = 2'b01; grant_idx = 1'b0; end
        2'b10: begin grant = 2'b10; grant_idx = 1'b1; end
        2'b11: begin
          if (r_last_grant) begin
            grant     = 2'b01;
            grant_idx = 1'b0;
          end else begin
            grant     = 2'b10;
            grant_idx = 1'b1;
          end
        end
        default: begin grant = 2'b00; grant_idx = 1'b0; end
      endcase
    end
  end

  // Starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      r_last_grant <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : spi_req_arbiter
// Brief   : Serialises two requesters onto an SPI master: TX write, status poll, RX read.
// Revision: 1.0
// ============================================================================
module spi_req_arbiter
  import spi_req_arbiter_pkg::*;
#(
  parameter logic [2:0]  ADDR_RXDR   = C_ADDR_RXDR,
  parameter logic [2:0]  ADDR_TXDR   = C_ADDR_TXDR,
  parameter logic [2:0]  ADDR_STATUS = C_ADDR_STATUS,
  parameter int          RRDY_BIT    = C_RRDY_BIT,
  parameter logic [15:0] TIMEOUT     = C_TIMEOUT
) (
  input  logic       I_CLK,
  input  logic       I_RESETN,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       spi_tx_en,
  output logic [2:0] spi_waddr,
  output logic [7:0] spi_wdata,
  output logic       spi_rx_en,
  output logic [2:0] spi_raddr,
  input  logic [7:0] spi_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic        w_arb_en;
  logic [1:0]  w_grant;
  logic        w_grant_idx;
  logic        w_take;
  logic        r_gnt_idx;
  logic [7:0]  r_tx_byte;
  logic [15:0] r_poll_cnt;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_err;
  logic        w_rrdy;
  logic        w_timeout;

  // Gating with reset keeps req_ready low while reset is held.
  assign w_arb_en  = (r_state == ST_IDLE) && I_RESETN;
  assign w_take    = w_arb_en && (req_valid != 2'b00);
  assign w_rrdy    = spi_rdata[RRDY_BIT];
  assign w_timeout = (r_poll_cnt == TIMEOUT);

  spi_rr_arb2 u_arb (
    .clk       (I_CLK),
    .rst_n     (I_RESETN),
    .req       (req_valid),
    .en        (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = 1'b1;
    spi_tx_en = 1'b0;
    spi_waddr = 3'd0;
    spi_wdata = 8'h00;
    spi_rx_en = 1'b0;
    spi_raddr = 3'd0;
    case (r_state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = w_grant;
        if (w_take) w_next = ST_WR_TX;
      end
      ST_WR_TX: begin
        spi_tx_en = 1'b1;
        spi_waddr = ADDR_TXDR;
        spi_wdata = r_tx_byte;
        w_next    = ST_POLL_REQ;
      end
      ST_POLL_REQ: begin
        spi_rx_en = 1'b1;
        spi_raddr = ADDR_STATUS;
        w_next    = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (w_rrdy)         w_next = ST_RD_REQ;
        else if (w_timeout) w_next = ST_RESP;
        else                w_next = ST_POLL_REQ;
      end
      ST_RD_REQ: begin
        spi_rx_en = 1'b1;
        spi_raddr = ADDR_RXDR;
        w_next    = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = {r_gnt_idx, ~r_gnt_idx};
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // The poll counter counts re-polls, so TIMEOUT=0 allows exactly one status read.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      r_gnt_idx  <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_poll_cnt <= 16'd0;
      r_rsp_data <= 8'h00;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_gnt_idx  <= w_grant_idx;
            r_tx_byte  <= w_grant_idx ? req_data1 : req_data0;
            r_poll_cnt <= 16'd0;
            r_rsp_err  <= 1'b0;
          end
        end
        ST_POLL_CHK: begin
          if (!w_rrdy) begin
            if (w_timeout) begin
              r_rsp_data <= 8'h00;
              r_rsp_err  <= 1'b1;
            end else begin
              r_poll_cnt <= sat_inc16(r_poll_cnt);
            end
          end
        end
        ST_RD_CAP: begin
          r_rsp_data <= spi_rdata;
          r_rsp_err  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_req_arbiter
// Brief   : Scoreboard bench for spi_req_arbiter with a behavioural SPI master model.
// Revision: 1.0
// ============================================================================
module tb_spi_req_arbiter;

  localparam logic [2:0] A_RX = 3'd0;
  localparam logic [2:0] A_TX = 3'd1;
  localparam logic [2:0] A_ST = 3'd2;

  logic       I_CLK = 1'b0;
  logic       I_RESETN = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       spi_tx_en;
  logic [2:0] spi_waddr;
  logic [7:0] spi_wdata;
  logic       spi_rx_en;
  logic [2:0] spi_raddr;
  logic [7:0] spi_rdata = 8'h00;

  always #5 I_CLK = ~I_CLK;

  spi_req_arbiter #(.TIMEOUT(16'd3)) dut (
    .I_CLK     (I_CLK),
    .I_RESETN  (I_RESETN),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .spi_tx_en (spi_tx_en),
    .spi_waddr (spi_waddr),
    .spi_wdata (spi_wdata),
    .spi_rx_en (spi_rx_en),
    .spi_raddr (spi_raddr),
    .spi_rdata (spi_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] data;
    logic       err;
    int         n_stat;
    int         n_rx;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int         rrdy_at = 1;
  logic [7:0] rx_byte = 8'h00;
  int         slv_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge I_CLK) cyc <= cyc + 1;

  // SPI master model: read data appears one cycle after spi_rx_en.
  // Not-ready status has every bit but RRDY set, and idle read data has RRDY set.
  always @(posedge I_CLK) begin
    if (req_ready != 2'b00) slv_cnt <= 0;
    if (spi_rx_en && spi_raddr == A_ST) begin
      slv_cnt   <= slv_cnt + 1;
      spi_rdata <= (rrdy_at != 0 && slv_cnt + 1 >= rrdy_at) ? 8'h08 : 8'hF7;
    end else if (spi_rx_en && spi_raddr == A_RX) begin
      spi_rdata <= rx_byte;
    end else begin
      spi_rdata <= 8'hEE;
    end
  end

  int         g_idx  = -1;
  int         g_cyc  = 0;
  int         n_stat = 0;
  int         n_rx   = 0;
  int         n_tx   = 0;
  logic [2:0] tx_a   = 3'd0;
  logic [7:0] tx_b   = 8'h00;

  always @(negedge I_CLK) begin
    if (!I_RESETN) begin
      g_idx  = -1;
      n_stat = 0;
      n_rx   = 0;
      n_tx   = 0;
    end else begin
      check("tx_rx_exclusive", 32'(spi_tx_en & spi_rx_en), 32'd0);
      check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("rsp_valid_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      if (req_ready != 2'b00) begin
        g_idx  = req_ready[1] ? 1 : 0;
        g_cyc  = cyc;
        n_stat = 0;
        n_rx   = 0;
        n_tx   = 0;
      end
      if (spi_tx_en) begin
        n_tx++;
        tx_a = spi_waddr;
        tx_b = spi_wdata;
      end
      if (spi_rx_en) begin
        if (spi_raddr == A_ST)      n_stat++;
        else if (spi_raddr == A_RX) n_rx++;
        else check("spi_raddr", 32'(spi_raddr), 32'(A_ST));
      end
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
        end else begin
          e = sb.pop_front();
          check("rsp_valid_bit", 32'(rsp_valid), (e.idx == 1) ? 32'd2 : 32'd1);
          check("grant_idx", 32'(g_idx), 32'(e.idx));
          check("tx_count", 32'(n_tx), 32'd1);
          check("tx_addr", 32'(tx_a), 32'(A_TX));
          check("tx_data", 32'(tx_b), 32'(e.tx));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("status_reads", 32'(n_stat), 32'(e.n_stat));
          check("rxdr_reads", 32'(n_rx), 32'(e.n_rx));
          check("latency", 32'(cyc - g_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic push(input int idx, input logic [7:0] tx, input logic [7:0] data,
                      input logic err, input int ns, input int nr, input int lat);
    exp_t x;
    x.idx = idx; x.tx = tx; x.data = data; x.err = err;
    x.n_stat = ns; x.n_rx = nr; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < limit) begin
      tick(1);
      k++;
    end
    total++;
    if (k >= limit) begin
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles", sb.size(), limit);
      sb.delete();
    end
  endtask

  task automatic single(input int idx, input logic [7:0] tx, input logic [7:0] rx, input int rr,
                        input logic [7:0] edata, input logic eerr, input int ns, input int nr,
                        input int lat);
    rrdy_at = rr;
    rx_byte = rx;
    push(idx, tx, edata, eerr, ns, nr, lat);
    if (idx == 0) req_data0 = tx; else req_data1 = tx;
    req_valid[idx] = 1'b1;
    tick(1);
    req_valid = 2'b00;
    wait_drain(200);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_tx_en"},     32'(spi_tx_en), 32'd0);
    check({tag, "_waddr"},     32'(spi_waddr), 32'd0);
    check({tag, "_wdata"},     32'(spi_wdata), 32'd0);
    check({tag, "_rx_en"},     32'(spi_rx_en), 32'd0);
    check({tag, "_raddr"},     32'(spi_raddr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    int k;

    tick(2);
    check_quiet("reset");

    // Both requesters held from reset: grants alternate 0,1,0,1.
    I_RESETN  = 1'b1;
    rrdy_at   = 1;
    rx_byte   = 8'h5A;
    req_data0 = 8'h11;
    req_data1 = 8'h22;
    push(0, 8'h11, 8'h5A, 1'b0, 1, 1, 6);
    push(1, 8'h22, 8'h5A, 1'b0, 1, 1, 6);
    push(0, 8'h11, 8'h5A, 1'b0, 1, 1, 6);
    push(1, 8'h22, 8'h5A, 1'b0, 1, 1, 6);
    req_valid = 2'b11;
    gcnt = 0;
    k    = 0;
    while (gcnt < 4 && k < 200) begin
      @(negedge I_CLK);
      if (req_ready != 2'b00) gcnt++;
      k++;
    end
    check("four_grants", 32'(gcnt), 32'd4);
    tick(1);
    req_valid = 2'b00;
    wait_drain(200);

    // Single request, RRDY on first poll.
    single(0, 8'hA5, 8'h3C, 1, 8'h3C, 1'b0, 1, 1, 6);
    // RRDY never set: TIMEOUT=3 gives four status reads then an error.
    single(1, 8'h77, 8'h99, 0, 8'h00, 1'b1, 4, 0, 10);
    // RRDY on third poll.
    single(0, 8'h5C, 8'hC3, 3, 8'hC3, 1'b0, 3, 1, 10);

    // A request that comes and goes while busy is ignored.
    rrdy_at   = 1;
    rx_byte   = 8'h34;
    req_data0 = 8'h12;
    req_data1 = 8'hEE;
    push(0, 8'h12, 8'h34, 1'b0, 1, 1, 6);
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    tick(1);
    req_valid = 2'b10;
    tick(2);
    req_valid = 2'b00;
    wait_drain(200);
    tick(3);

    // Reset in POLL_CHK abandons the transaction.
    rrdy_at   = 0;
    req_data0 = 8'h66;
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    k = 0;
    while (!(spi_rx_en && spi_raddr == A_ST) && k < 50) begin
      @(negedge I_CLK);
      k++;
    end
    check("reached_poll", 32'(spi_rx_en), 32'd1);
    @(posedge I_CLK);
    #2;
    I_RESETN = 1'b0;
    #1;
    check_quiet("midreset");
    tick(2);
    I_RESETN = 1'b1;

    // After reset requester 0 wins the tie again.
    rrdy_at   = 1;
    rx_byte   = 8'h18;
    req_data0 = 8'h81;
    req_data1 = 8'h82;
    push(0, 8'h81, 8'h18, 1'b0, 1, 1, 6);
    req_valid = 2'b11;
    tick(1);
    req_valid = 2'b00;
    wait_drain(200);
    tick(3);

    check("queue_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
